// File: rtl/pingpong_pkg.sv
// ============================================================================
// Module      : pingpong_pkg
// Description : Shared bank-state encoding and default sizing for the
//               ping-pong frame buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pingpong_pkg;

    localparam int C_DATA_WIDTH = 18;
    localparam int C_MEM_DEPTH  = 1200;
    localparam int C_ADDR_WIDTH = 11;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

endpackage

`default_nettype wire

// File: rtl/pingpong_bank_ram.sv
// ============================================================================
// Module      : pingpong_bank_ram
// Description : One frame bank: simple dual-port RAM, one write port and one
//               registered read port. The array is never reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pingpong_bank_ram
    import pingpong_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int MEM_DEPTH  = C_MEM_DEPTH,
    parameter int ADDR_WIDTH = C_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [0:MEM_DEPTH-1];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Callers only enable a port with an address below MEM_DEPTH.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            rd_data_q <= mem_q[i_rd_addr];
        end
    end

    assign o_rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/pingpong_frame_buf.sv
// ============================================================================
// Module      : pingpong_frame_buf
// Description : Two-bank ping-pong frame buffer between a symbol mapper and an
//               FFT. Optional sticky error flags: PINGPONG_FRAME_BUF_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pingpong_frame_buf
    import pingpong_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int MEM_DEPTH  = C_MEM_DEPTH,
    parameter int ADDR_WIDTH = C_ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  wr_last,
    input  logic [ADDR_WIDTH-1:0] frame_len,
    output logic                  wr_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    input  logic                  rd_ready,
    output logic [1:0]            frames_pending,
    input  logic                  err_clr,
    output logic                  err_overflow,
    output logic                  err_addr
);

    localparam logic [ADDR_WIDTH-1:0] C_DEPTH = ADDR_WIDTH'(MEM_DEPTH);

    if ((2 ** ADDR_WIDTH) < (MEM_DEPTH + 1)) begin : g_cfg_check
        $error("pingpong_frame_buf: ADDR_WIDTH too small to hold MEM_DEPTH as a length");
    end

    bank_state_t             bank_st_q  [0:1];
    bank_state_t             bank_st_d  [0:1];
    logic [ADDR_WIDTH-1:0]   bank_len_q [0:1];
    logic [ADDR_WIDTH-1:0]   bank_len_d [0:1];

    logic                    wr_sel_q, wr_sel_d;
    logic                    rd_sel_q, rd_sel_d;
    logic [ADDR_WIDTH-1:0]   rd_idx_q, rd_idx_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    rd_last_q, rd_last_d;

    logic                    w_wr_beat;
    logic                    w_addr_ok;
    logic [ADDR_WIDTH-1:0]   w_len_clamped;
    bank_state_t             w_rd_st;
    logic [ADDR_WIDTH-1:0]   w_rd_len;
    logic                    w_rd_hs;
    logic                    w_fetch;
    logic [DATA_WIDTH-1:0]   w_ram_rd [0:1];

    assign wr_ready      = (bank_st_q[wr_sel_q] == BANK_EMPTY) ||
                           (bank_st_q[wr_sel_q] == BANK_FILLING);
    assign w_wr_beat     = wr_valid && wr_ready;
    assign w_addr_ok     = (wr_addr < C_DEPTH);
    assign w_len_clamped = (frame_len > C_DEPTH) ? C_DEPTH : frame_len;

    assign w_rd_st  = bank_st_q[rd_sel_q];
    assign w_rd_len = bank_len_q[rd_sel_q];
    assign w_rd_hs  = rd_valid_q && rd_ready;
    // Fetching straight out of FULL saves a cycle at the frame boundary.
    assign w_fetch  = ((w_rd_st == BANK_FULL) || (w_rd_st == BANK_DRAINING)) &&
                      (rd_idx_q < w_rd_len) && (!rd_valid_q || rd_ready);

    always_comb begin
        bank_st_d  = bank_st_q;
        bank_len_d = bank_len_q;
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        rd_idx_d   = rd_idx_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;

        // Write and read sides never touch the same bank in one cycle: the
        // write side only acts on EMPTY/FILLING, the read side on FULL/DRAINING.
        if (w_wr_beat) begin
            if (!wr_last) begin
                bank_st_d[wr_sel_q] = BANK_FILLING;
            end else if (frame_len == '0) begin
                bank_st_d[wr_sel_q] = BANK_EMPTY;
            end else begin
                bank_st_d[wr_sel_q]  = BANK_FULL;
                bank_len_d[wr_sel_q] = w_len_clamped;
                wr_sel_d             = ~wr_sel_q;
            end
        end

        if (w_rd_hs && rd_last_q) begin
            bank_st_d[rd_sel_q] = BANK_EMPTY;
            rd_sel_d            = ~rd_sel_q;
            rd_idx_d            = '0;
            rd_valid_d          = 1'b0;
            rd_last_d           = 1'b0;
        end else if (w_fetch) begin
            bank_st_d[rd_sel_q] = BANK_DRAINING;
            rd_idx_d            = rd_idx_q + 1'b1;
            rd_valid_d          = 1'b1;
            rd_last_d           = (rd_idx_q == (w_rd_len - 1'b1));
        end else if (w_rd_hs) begin
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bank_st_q[0]  <= BANK_EMPTY;
            bank_st_q[1]  <= BANK_EMPTY;
            bank_len_q[0] <= '0;
            bank_len_q[1] <= '0;
            wr_sel_q      <= 1'b0;
            rd_sel_q      <= 1'b0;
            rd_idx_q      <= '0;
            rd_valid_q    <= 1'b0;
            rd_last_q     <= 1'b0;
        end else begin
            bank_st_q     <= bank_st_d;
            bank_len_q    <= bank_len_d;
            wr_sel_q      <= wr_sel_d;
            rd_sel_q      <= rd_sel_d;
            rd_idx_q      <= rd_idx_d;
            rd_valid_q    <= rd_valid_d;
            rd_last_q     <= rd_last_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        pingpong_bank_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .MEM_DEPTH  (MEM_DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_ram (
            .clk       (CLK),
            .i_wr_en   (w_wr_beat && w_addr_ok && (wr_sel_q == 1'(gi))),
            .i_wr_addr (wr_addr),
            .i_wr_data (wr_data),
            .i_rd_en   (w_fetch && (rd_sel_q == 1'(gi))),
            .i_rd_addr (rd_idx_q),
            .o_rd_data (w_ram_rd[gi])
        );
    end

    // The RAM read register is the output register; gating keeps rd_data at
    // zero after reset without resetting the array.
    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign rd_data  = rd_valid_q ? w_ram_rd[rd_sel_q] : '0;

    assign frames_pending =
        {1'b0, (bank_st_q[0] == BANK_FULL) || (bank_st_q[0] == BANK_DRAINING)} +
        {1'b0, (bank_st_q[1] == BANK_FULL) || (bank_st_q[1] == BANK_DRAINING)};

`ifdef PINGPONG_FRAME_BUF_ERR_EN
    logic err_overflow_q, err_overflow_d;
    logic err_addr_q, err_addr_d;

    // A new error event overrides a coincident clear.
    always_comb begin
        err_overflow_d = err_overflow_q;
        err_addr_d     = err_addr_q;
        if (err_clr) begin
            err_overflow_d = 1'b0;
            err_addr_d     = 1'b0;
        end
        if (wr_valid && !wr_ready) begin
            err_overflow_d = 1'b1;
        end
        if (w_wr_beat && !w_addr_ok) begin
            err_addr_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_overflow_q <= 1'b0;
            err_addr_q     <= 1'b0;
        end else begin
            err_overflow_q <= err_overflow_d;
            err_addr_q     <= err_addr_d;
        end
    end

    assign err_overflow = err_overflow_q;
    assign err_addr     = err_addr_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_overflow   = 1'b0;
    assign err_addr       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pingpong_frame_buf.sv
// ============================================================================
// Module      : tb_pingpong_frame_buf
// Description : Directed self-checking bench for pingpong_frame_buf.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pingpong_frame_buf;

    localparam int DW = 18;
    localparam int AW = 11;

`ifdef PINGPONG_FRAME_BUF_ERR_EN
    localparam logic C_ERR_EN = 1'b1;
`else
    localparam logic C_ERR_EN = 1'b0;
`endif

    logic          CLK;
    logic          RST;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_addr;
    logic          wr_last;
    logic [AW-1:0] frame_len;
    logic          wr_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          rd_ready;
    logic [1:0]    frames_pending;
    logic          err_clr;
    logic          err_overflow;
    logic          err_addr;

    typedef struct {
        logic [31:0] w;
        int          cyc;
    } rx_t;

    rx_t         rx_q[$];
    int          cyc_cnt    = 0;
    int          n_checks   = 0;
    int          n_fail     = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_word  = '0;

    pingpong_frame_buf u_dut (
        .CLK            (CLK),
        .RST            (RST),
        .wr_valid       (wr_valid),
        .wr_data        (wr_data),
        .wr_addr        (wr_addr),
        .wr_last        (wr_last),
        .frame_len      (frame_len),
        .wr_ready       (wr_ready),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .rd_last        (rd_last),
        .rd_ready       (rd_ready),
        .frames_pending (frames_pending),
        .err_clr        (err_clr),
        .err_overflow   (err_overflow),
        .err_addr       (err_addr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wd(input int d, input bit l);
        return {13'd0, l, 18'(d)};
    endfunction

    // Output monitor: records handshakes and checks that stalled words hold.
    always @(negedge CLK) begin
        if (RST) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", 32'(rd_valid), 32'd1);
                check_eq("stall_hold", {13'd0, rd_last, rd_data}, prev_word);
            end
            if (rd_valid && rd_ready)
                rx_q.push_back('{w: {13'd0, rd_last, rd_data}, cyc: cyc_cnt});
            prev_stall <= rd_valid && !rd_ready;
            prev_word  <= {13'd0, rd_last, rd_data};
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr_beat(input int a, input int d, input bit last, input int len);
        wr_valid  = 1'b1;
        wr_addr   = AW'(a);
        wr_data   = DW'(d);
        wr_last   = last;
        frame_len = AW'(len);
        cyc();
        wr_valid  = 1'b0;
        wr_last   = 1'b0;
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && rx_q.size() < n; i++) cyc();
        check_eq(tag, 32'(rx_q.size()), 32'(n));
    endtask

    task automatic pop_word(input string tag, input int d, input bit l, output int c);
        rx_t e;
        c = -1;
        check_eq({tag, "_avail"}, 32'(rx_q.size() > 0), 32'd1);
        if (rx_q.size() > 0) begin
            e = rx_q.pop_front();
            c = e.cyc;
            check_eq(tag, e.w, wd(d, l));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, cp, gaps;
        int c3, c4;

        RST = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_addr = '0; wr_last = 1'b0;
        frame_len = '0; rd_ready = 1'b0; err_clr = 1'b0;
        repeat (3) cyc();
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_rd_last", 32'(rd_last), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        check_eq("rst_pending", 32'(frames_pending), 32'd0);
        check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
        check_eq("rst_err_ovf", 32'(err_overflow), 32'd0);
        check_eq("rst_err_addr", 32'(err_addr), 32'd0);
        RST = 1'b0;

        // Full-size frame, streaming read
        rd_ready = 1'b1;
        for (int i = 0; i < 1200; i++) wr_beat(i, i, (i == 1199), 1200);
        wait_rx("t1_count", 1200, 1400);
        gaps = 0; cp = 0;
        for (int i = 0; i < 1200; i++) begin
            pop_word($sformatf("t1_w%0d", i), i, (i == 1199), c);
            if (i > 0 && c != cp + 1) gaps++;
            cp = c;
        end
        check_eq("t1_gaps", 32'(gaps), 32'd0);
        check_eq("t1_pending", 32'(frames_pending), 32'd0);

        // Two frames with the reader stalled
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr_beat(i, 10 + i, (i == 3), 4);
        for (int i = 0; i < 4; i++) wr_beat(i, 20 + i, (i == 3), 4);
        check_eq("t2_wr_ready", 32'(wr_ready), 32'd0);
        check_eq("t2_pending", 32'(frames_pending), 32'd2);
        wr_beat(0, 99, 1'b0, 0);
        check_eq("t2_err_ovf", 32'(err_overflow), 32'(C_ERR_EN));
        check_eq("t2_no_rx", 32'(rx_q.size()), 32'd0);
        rd_ready = 1'b1;
        wait_rx("t2_count", 8, 40);
        c3 = 0; c4 = 0;
        for (int i = 0; i < 4; i++) begin
            pop_word($sformatf("t2_a%0d", i), 10 + i, (i == 3), c);
            if (i == 3) c3 = c;
        end
        for (int i = 0; i < 4; i++) begin
            pop_word($sformatf("t2_b%0d", i), 20 + i, (i == 3), c);
            if (i == 0) c4 = c;
        end
        check_eq("t2_bubble", 32'((c4 - c3) <= 2), 32'd1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check_eq("t2_err_ovf_clr", 32'(err_overflow), 32'd0);

        // Ready toggling during a drain
        rd_ready = 1'b0;
        for (int i = 0; i < 6; i++) wr_beat(i, 30 + i, (i == 5), 6);
        for (int i = 0; i < 40 && rx_q.size() < 6; i++) begin
            rd_ready = (i % 2 == 0);
            cyc();
        end
        rd_ready = 1'b1;
        wait_rx("t3_count", 6, 20);
        for (int i = 0; i < 6; i++) pop_word($sformatf("t3_w%0d", i), 30 + i, (i == 5), c);

        // Out-of-range address: dropped, stale word read back
        wr_beat(0, 40, 1'b0, 0);
        wr_beat(1500, 777, 1'b0, 0);
        check_eq("t4_err_addr", 32'(err_addr), 32'(C_ERR_EN));
        wr_beat(2, 42, 1'b1, 3);
        wait_rx("t4_count", 3, 20);
        pop_word("t4_w0", 40, 1'b0, c);
        pop_word("t4_w1", 21, 1'b0, c);
        pop_word("t4_w2", 42, 1'b1, c);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check_eq("t4_err_addr_clr", 32'(err_addr), 32'd0);

        // Reset while bank 0 drains and bank 1 fills
        wr_beat(0, 45, 1'b0, 0);
        wr_beat(1, 46, 1'b1, 2);
        wait_rx("t5_x_count", 2, 20);
        pop_word("t5_x0", 45, 1'b0, c);
        pop_word("t5_x1", 46, 1'b1, c);
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr_beat(i, 50 + i, (i == 3), 4);
        cyc();
        check_eq("t5_draining", 32'(rd_valid), 32'd1);
        check_eq("t5_pending", 32'(frames_pending), 32'd1);
        wr_beat(0, 55, 1'b0, 0);
        wr_beat(1, 56, 1'b0, 0);
        err_clr = 1'b1;
        wr_beat(1500, 0, 1'b0, 0);
        err_clr = 1'b0;
        check_eq("t5_err_wins", 32'(err_addr), 32'(C_ERR_EN));
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        check_eq("t5_rst_valid", 32'(rd_valid), 32'd0);
        check_eq("t5_rst_data", 32'(rd_data), 32'd0);
        check_eq("t5_rst_pending", 32'(frames_pending), 32'd0);
        check_eq("t5_rst_wr_ready", 32'(wr_ready), 32'd1);
        check_eq("t5_rst_err_addr", 32'(err_addr), 32'd0);
        check_eq("t5_rst_no_rx", 32'(rx_q.size()), 32'd0);
        rd_ready = 1'b1;
        wr_beat(0, 60, 1'b0, 0);
        wr_beat(2, 62, 1'b1, 3);
        wait_rx("t5_z_count", 3, 20);
        pop_word("t5_z0", 60, 1'b0, c);
        pop_word("t5_z1", 51, 1'b0, c);
        pop_word("t5_z2", 62, 1'b1, c);

        // Zero-length frame
        wr_beat(0, 70, 1'b1, 0);
        repeat (6) cyc();
        check_eq("t6_no_rx", 32'(rx_q.size()), 32'd0);
        check_eq("t6_pending", 32'(frames_pending), 32'd0);
        check_eq("t6_wr_ready", 32'(wr_ready), 32'd1);
        check_eq("t6_rd_valid", 32'(rd_valid), 32'd0);
        wr_beat(0, 80, 1'b0, 0);
        wr_beat(2, 82, 1'b1, 3);
        wait_rx("t6_count", 3, 20);
        pop_word("t6_w0", 80, 1'b0, c);
        pop_word("t6_w1", 56, 1'b0, c);
        pop_word("t6_w2", 82, 1'b1, c);

        repeat (2) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
